// File: rtl/led_event_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// led_event_scheduler_pkg
//
// Shared definitions for the status-LED event scheduler and its helpers:
//   - FSM state encoding (IDLE=0, ON=1, OFF=2, GAP=3)
//   - parameter range limits for source count and phase durations
//   - counter widths
//   - ticks_to_load(): clamps a phase duration into the legal 1..255 range
//     so the phase counter can never be loaded with 0 (which would make
//     the phase last a full 256-tick wrap instead of the requested length).
// -----------------------------------------------------------------------------
package led_event_scheduler_pkg;

    // Parameter range limits
    localparam int SRC_MIN   = 1;
    localparam int SRC_MAX   = 8;
    localparam int TICKS_MIN = 1;
    localparam int TICKS_MAX = 255;

    // Counter / index widths
    localparam int PHASE_W = 8;
    localparam int BLINK_W = 4;
    localparam int IDX_W   = 3;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    // Clamp a phase duration into the range the phase counter supports.
    function automatic logic [PHASE_W-1:0] ticks_to_load(input int ticks);
        if (ticks < TICKS_MIN) begin
            return PHASE_W'(TICKS_MIN);
        end else if (ticks > TICKS_MAX) begin
            return PHASE_W'(TICKS_MAX);
        end else begin
            return PHASE_W'(ticks);
        end
    endfunction

endpackage

// File: rtl/led_prio_pick.sv
// -----------------------------------------------------------------------------
// led_prio_pick
//
// Combinational lowest-set-bit priority encoder. Bit 0 has the highest
// priority. Reusable by any arbiter that needs "first requester wins".
//
// Parameters:
//   N      number of request lines (1..8)
// Ports:
//   req    input  [N-1:0]  request vector
//   valid  output          at least one request bit is set
//   idx    output [2:0]    index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module led_prio_pick
    import led_event_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the last hit (lowest index) is what sticks.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/led_event_scheduler.sv
// -----------------------------------------------------------------------------
// led_event_scheduler
//
// Shares one front-panel status LED among up to eight one-cycle event
// sources. Each event is latched as pending; the lowest-index pending source
// is granted the LED and shown as a blink code (source i blinks i+1 times),
// followed by a dark inter-code gap. Phase timing counts the prescaler tick
// strobe, so only small 8-bit counters are needed.
//
// Parameters:
//   NUM_SRC    number of event sources (1..8)
//   ON_TICKS   ticks the LED is lit per blink (1..255)
//   OFF_TICKS  ticks dark between blinks of one code (1..255)
//   GAP_TICKS  ticks dark after a code completes (1..255)
// Ports:
//   clk          input                system clock
//   reset        input                asynchronous active-high reset
//   tick         input                one-cycle timebase strobe
//   event_pulse  input  [NUM_SRC-1:0] one-cycle request per source (bit 0 highest)
//   led          output               shared LED drive
//   busy         output               high while a code is in progress
//   active_src   output [2:0]         source being served, 0 when idle
//   pending      output [NUM_SRC-1:0] latched, not-yet-served requests
//   done         output               one-cycle pulse when a code's gap ends
// -----------------------------------------------------------------------------
module led_event_scheduler
    import led_event_scheduler_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 1,
    parameter int GAP_TICKS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [NUM_SRC-1:0] event_pulse,
    output logic               led,
    output logic               busy,
    output logic [2:0]         active_src,
    output logic [NUM_SRC-1:0] pending,
    output logic               done
);

    localparam logic [PHASE_W-1:0] ON_LOAD  = ticks_to_load(ON_TICKS);
    localparam logic [PHASE_W-1:0] OFF_LOAD = ticks_to_load(OFF_TICKS);
    localparam logic [PHASE_W-1:0] GAP_LOAD = ticks_to_load(GAP_TICKS);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t             state_reg,   state_next;
    logic [PHASE_W-1:0] phase_reg,   phase_next;
    logic [BLINK_W-1:0] blink_reg,   blink_next;
    logic               led_reg,     led_next;
    logic               busy_reg,    busy_next;
    logic [IDX_W-1:0]   src_reg,     src_next;
    logic               done_reg,    done_next;
    logic [NUM_SRC-1:0] pending_reg, pending_next;

    // -------------------------------------------------------------------------
    // Arbitration on the registered pending vector
    // -------------------------------------------------------------------------
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant;
    logic [NUM_SRC-1:0] clear_mask;

    led_prio_pick #(
        .N (NUM_SRC)
    ) u_pick (
        .req   (pending_reg),
        .valid (grant_valid),
        .idx   (grant_idx)
    );

    // A grant can only happen from IDLE; no preemption of a running code.
    assign grant = (state_reg == ST_IDLE) && grant_valid;

    // One-hot clear for the source being granted this cycle.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_clear
            assign clear_mask[gi] = grant && (grant_idx == IDX_W'(gi));
        end
    endgenerate

    // Set after clear: a fresh event from the granted source (or any source)
    // in the grant cycle keeps its bit pending. Repeat events simply merge.
    always_comb begin
        pending_next = (pending_reg & ~clear_mask) | event_pulse;
    end

    // -------------------------------------------------------------------------
    // Blink-code FSM next-state / registered-output logic
    // -------------------------------------------------------------------------
    logic               phase_last;
    logic [BLINK_W-1:0] blink_dec;

    // The tick that takes the counter from 1 to 0 ends the phase. Treating 0
    // as "last" too keeps a stray zero from turning into a 256-tick phase.
    assign phase_last = (phase_reg <= PHASE_W'(1));

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        blink_next = blink_reg;
        led_next   = led_reg;
        busy_next  = busy_reg;
        src_next   = src_reg;
        done_next  = 1'b0;
        blink_dec  = blink_reg - BLINK_W'(1);

        case (state_reg)
            ST_IDLE: begin
                // Ticks here are ignored, so a tick in the grant cycle is
                // never charged to the ON phase being loaded.
                if (grant_valid) begin
                    state_next = ST_ON;
                    led_next   = 1'b1;
                    busy_next  = 1'b1;
                    phase_next = ON_LOAD;
                    blink_next = {1'b0, grant_idx} + BLINK_W'(1);
                    src_next   = grant_idx;
                end
            end

            ST_ON: begin
                if (tick) begin
                    if (phase_last) begin
                        blink_next = blink_dec;
                        led_next   = 1'b0;
                        if (blink_dec != '0) begin
                            state_next = ST_OFF;
                            phase_next = OFF_LOAD;
                        end else begin
                            state_next = ST_GAP;
                            phase_next = GAP_LOAD;
                        end
                    end else begin
                        phase_next = phase_reg - PHASE_W'(1);
                    end
                end
            end

            ST_OFF: begin
                if (tick) begin
                    if (phase_last) begin
                        state_next = ST_ON;
                        led_next   = 1'b1;
                        phase_next = ON_LOAD;
                    end else begin
                        phase_next = phase_reg - PHASE_W'(1);
                    end
                end
            end

            ST_GAP: begin
                if (tick) begin
                    if (phase_last) begin
                        state_next = ST_IDLE;
                        phase_next = '0;
                        busy_next  = 1'b0;
                        src_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        phase_next = phase_reg - PHASE_W'(1);
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                phase_next = '0;
                blink_next = '0;
                led_next   = 1'b0;
                busy_next  = 1'b0;
                src_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. Reset aborts any code in flight and drops all requests.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            phase_reg   <= '0;
            blink_reg   <= '0;
            led_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            src_reg     <= '0;
            done_reg    <= 1'b0;
            pending_reg <= '0;
        end else begin
            state_reg   <= state_next;
            phase_reg   <= phase_next;
            blink_reg   <= blink_next;
            led_reg     <= led_next;
            busy_reg    <= busy_next;
            src_reg     <= src_next;
            done_reg    <= done_next;
            pending_reg <= pending_next;
        end
    end

    assign led        = led_reg;
    assign busy       = busy_reg;
    assign active_src = src_reg;
    assign pending    = pending_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_led_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_led_event_scheduler
//
// Directed bench for led_event_scheduler. Instance dut uses the default
// timing (ON=2, OFF=1, GAP=3) with a tick every 4 clocks; instance dut1 uses
// ON_TICKS=1 with a tick on every clock. A monitor records, for each code,
// the LED level at every counted tick (while busy), so a code's blink
// pattern can be compared against a hand-written bit string.
// -----------------------------------------------------------------------------
module tb_led_event_scheduler;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [3:0] event_pulse;
    logic       led;
    logic       busy;
    logic [2:0] active_src;
    logic [3:0] pending;
    logic       done;

    logic       tick1;
    logic [3:0] event_pulse1;
    logic       led1;
    logic       busy1;
    logic [2:0] active_src1;
    logic [3:0] pending1;
    logic       done1;

    led_event_scheduler #(
        .NUM_SRC   (4),
        .ON_TICKS  (2),
        .OFF_TICKS (1),
        .GAP_TICKS (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .event_pulse (event_pulse),
        .led         (led),
        .busy        (busy),
        .active_src  (active_src),
        .pending     (pending),
        .done        (done)
    );

    led_event_scheduler #(
        .NUM_SRC   (4),
        .ON_TICKS  (1),
        .OFF_TICKS (1),
        .GAP_TICKS (3)
    ) dut1 (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick1),
        .event_pulse (event_pulse1),
        .led         (led1),
        .busy        (busy1),
        .active_src  (active_src1),
        .pending     (pending1),
        .done        (done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] pat;
        int          n;
        int          src;
        bit          stable;
    } code_t;

    code_t codes[$];
    int    done_cnt = 0;

    logic [31:0] m_pat;
    int          m_n;
    int          m_src;
    bit          m_started;
    bit          m_stable;

    logic [31:0] m1_pat;
    int          m1_n;
    logic [31:0] m1_last_pat;
    int          m1_last_n;
    int          done1_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = ((cyc % 4) == 0);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic wait_done1(input string tag);
        int k;
        k = 0;
        while (done1 !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        check({tag, "_done_seen"}, 32'(done1), 32'd1);
    endtask

    task automatic expect_code(input string tag, input int src, input int n, input logic [31:0] pat);
        code_t c;
        if (codes.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            c = codes.pop_front();
            check({tag, "_src"},    32'(c.src),    32'(src));
            check({tag, "_ticks"},  32'(c.n),      32'(n));
            check({tag, "_pat"},    c.pat,         pat);
            check({tag, "_stable"}, 32'(c.stable), 32'd1);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitors (sample on the falling edge, away from the active edge)
    // -------------------------------------------------------------------------
    initial begin
        m_pat = '0; m_n = 0; m_src = 0; m_started = 1'b0; m_stable = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_pat = '0; m_n = 0; m_started = 1'b0; m_stable = 1'b1;
            end else begin
                if (busy) begin
                    if (!m_started) begin
                        m_src     = int'(active_src);
                        m_started = 1'b1;
                    end else if (int'(active_src) != m_src) begin
                        m_stable = 1'b0;
                    end
                    if (tick) begin
                        m_pat = {m_pat[30:0], led};
                        m_n++;
                    end
                end
                if (done) begin
                    codes.push_back('{m_pat, m_n, m_src, m_stable});
                    done_cnt++;
                    m_pat = '0; m_n = 0; m_started = 1'b0; m_stable = 1'b1;
                end
            end
        end
    end

    initial begin
        m1_pat = '0; m1_n = 0; m1_last_pat = '0; m1_last_n = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m1_pat = '0; m1_n = 0;
            end else begin
                if (busy1 && tick1) begin
                    m1_pat = {m1_pat[30:0], led1};
                    m1_n++;
                end
                if (done1) begin
                    m1_last_pat = m1_pat;
                    m1_last_n   = m1_n;
                    done1_cnt++;
                    m1_pat = '0; m1_n = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    initial begin
        int done_before;
        int k;
        bit busy_seen;
        bit done_seen;

        reset        = 1'b1;
        tick         = 1'b0;
        event_pulse  = '0;
        tick1        = 1'b0;
        event_pulse1 = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // ---- Reset state ----
        check("rst_led",     32'(led),        32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_src",     32'(active_src), 32'd0);
        check("rst_pending", 32'(pending),    32'd0);
        check("rst_done",    32'(done),       32'd0);
        $display("[TB] reset state checked");

        // ---- Single source 1: latency and pattern 2 on,1 off,2 on,3 gap ----
        done_before = done_cnt;
        event_pulse = 4'b0010;
        step();
        event_pulse = 4'b0000;
        check("s1_pending_c1", 32'(pending), 32'h2);
        check("s1_led_c1",     32'(led),     32'd0);
        step();
        check("s1_led_c2",     32'(led),        32'd1);
        check("s1_busy_c2",    32'(busy),       32'd1);
        check("s1_src_c2",     32'(active_src), 32'd1);
        check("s1_pending_c2", 32'(pending),    32'h0);
        wait_done("s1");
        check("s1_src_at_done",  32'(active_src), 32'd0);
        check("s1_busy_at_done", 32'(busy),       32'd0);
        repeat (10) step();
        check("s1_done_once", 32'(done_cnt - done_before), 32'd1);
        expect_code("s1_code", 1, 8, 32'b11011000);
        $display("[TB] single source 1 code checked");

        // ---- Simultaneous 1010: source 1 then source 3 ----
        event_pulse = 4'b1010;
        step();
        event_pulse = 4'b0000;
        check("sim_pending_a", 32'(pending), 32'ha);
        step();
        check("sim_src_first", 32'(active_src), 32'd1);
        check("sim_pending_b", 32'(pending),    32'h8);
        wait_done("sim_first");
        check("sim_pending_at_done", 32'(pending), 32'h8);
        step();
        check("sim_src_second", 32'(active_src), 32'd3);
        check("sim_pending_c",  32'(pending),    32'h0);
        wait_done("sim_second");
        step();
        expect_code("sim_code1", 1, 8,  32'b11011000);
        expect_code("sim_code3", 3, 14, 32'b11011011011000);
        $display("[TB] simultaneous 1010 checked");

        // ---- Source 2 served, source 0 arrives mid-code (no preemption) ----
        event_pulse = 4'b0100;
        step();
        event_pulse = 4'b0000;
        step();
        repeat (10) step();
        event_pulse = 4'b0001;
        step();
        event_pulse = 4'b0000;
        check("np_pending_mid", 32'(pending),    32'h1);
        check("np_src_mid",     32'(active_src), 32'd2);
        wait_done("np_src2");
        step();
        check("np_src0_grant", 32'(active_src), 32'd0);
        check("np_led_grant",  32'(led),        32'd1);
        check("np_busy_grant", 32'(busy),       32'd1);
        wait_done("np_src0");
        step();
        expect_code("np_code2", 2, 11, 32'b11011011000);
        expect_code("np_code0", 0, 5,  32'b11000);
        $display("[TB] no-preemption sequence checked");

        // ---- Source 0 re-arms during its own code ----
        event_pulse = 4'b0001;
        step();
        event_pulse = 4'b0000;
        step();
        repeat (2) step();
        event_pulse = 4'b0001;
        step();
        event_pulse = 4'b0000;
        check("rearm_pending", 32'(pending), 32'h1);
        check("rearm_busy",    32'(busy),    32'd1);
        wait_done("rearm_first");
        step();
        check("rearm_src_again",  32'(active_src), 32'd0);
        check("rearm_busy_again", 32'(busy),       32'd1);
        check("rearm_pending_clr", 32'(pending),   32'h0);
        wait_done("rearm_second");
        step();
        expect_code("rearm_code_a", 0, 5, 32'b11000);
        expect_code("rearm_code_b", 0, 5, 32'b11000);
        $display("[TB] re-arm during own code checked");

        // ---- Reset during OFF of source 3 with pending 0011 ----
        event_pulse = 4'b1000;
        step();
        event_pulse = 4'b0000;
        step();
        event_pulse = 4'b0011;
        step();
        event_pulse = 4'b0000;
        check("rst_mid_pending_pre", 32'(pending),    32'h3);
        check("rst_mid_src_pre",     32'(active_src), 32'd3);
        k = 0;
        while (!(busy && !led) && k < 100) begin
            step();
            k++;
        end
        check("rst_mid_in_off", 32'(busy && !led), 32'd1);
        done_before = done_cnt;
        reset = 1'b1;
        #1;
        check("rst_mid_led",     32'(led),        32'd0);
        check("rst_mid_busy",    32'(busy),       32'd0);
        check("rst_mid_pending", 32'(pending),    32'h0);
        check("rst_mid_src",     32'(active_src), 32'd0);
        repeat (2) step();
        reset = 1'b0;
        busy_seen = 1'b0;
        done_seen = 1'b0;
        repeat (20) begin
            step();
            busy_seen = busy_seen | busy;
            done_seen = done_seen | done;
        end
        check("rst_mid_stays_idle", 32'(busy_seen),            32'd0);
        check("rst_mid_no_done",    32'(done_seen),            32'd0);
        check("rst_mid_done_cnt",   32'(done_cnt - done_before), 32'd0);
        check("rst_mid_pending_post", 32'(pending),            32'h0);
        event_pulse = 4'b0100;
        step();
        event_pulse = 4'b0000;
        step();
        check("rst_mid_new_src",  32'(active_src), 32'd2);
        check("rst_mid_new_busy", 32'(busy),       32'd1);
        wait_done("rst_mid_new");
        step();
        expect_code("rst_mid_code2", 2, 11, 32'b11011011000);
        $display("[TB] reset during OFF checked");

        // ---- ON_TICKS=1, tick every cycle including the grant cycle ----
        tick1        = 1'b1;
        event_pulse1 = 4'b0010;
        step();
        event_pulse1 = 4'b0000;
        check("t1_pending", 32'(pending1), 32'h2);
        step();
        check("t1_led_on",  32'(led1),        32'd1);
        check("t1_src",     32'(active_src1), 32'd1);
        step();
        check("t1_led_off_after_one", 32'(led1), 32'd0);
        wait_done1("t1_src1");
        step();
        check("t1_code1_ticks", 32'(m1_last_n), 32'd6);
        check("t1_code1_pat",   m1_last_pat,    32'b101000);
        event_pulse1 = 4'b0001;
        step();
        event_pulse1 = 4'b0000;
        wait_done1("t1_src0");
        step();
        check("t1_code0_ticks", 32'(m1_last_n), 32'd4);
        check("t1_code0_pat",   m1_last_pat,    32'b1000);
        check("t1_done_count",  32'(done1_cnt), 32'd2);
        tick1 = 1'b0;
        $display("[TB] ON_TICKS=1 every-cycle tick checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
